// File: rtl/dmem_pkg.sv
// Shared types and defaults for the MEM-stage data memory responder.
// Holds the FSM state type and the address-error rule.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned LATENCY_DEFAULT     = 2;
    localparam int unsigned DEPTH_WORDS_DEFAULT = 256;
    localparam int unsigned CNT_W               = 4;

    // Misaligned or beyond the last word (unsigned compare).
    function automatic logic addr_err(
        input logic [31:0] addr,
        input int unsigned depth
    );
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables.
// Contents are deliberately not reset.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = 8
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // One access per enabled edge: lane-masked write plus registered read.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: one outstanding request, fixed latency,
// single-cycle response pulse and a stall request to the hazard unit.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int unsigned LATENCY     = LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    localparam int unsigned AW =
        (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             err_q, err_d;

    logic        accept;
    logic        enter_resp;
    logic        cur_write;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_be;
    logic        cur_err;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;

    assign accept = req_valid && (state_q == ST_IDLE);

    // With LATENCY=1 the RAM access happens on the accept edge itself,
    // so the live inputs are used while idle and the latched copy after.
    assign cur_write = (state_q == ST_IDLE) ? req_write : write_q;
    assign cur_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign cur_be    = (state_q == ST_IDLE) ? req_be    : be_q;
    assign cur_err   = addr_err(cur_addr, DEPTH_WORDS);

    // Commit/sample only on the edge entering RESP, never while in reset.
    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign ram_en     = enter_resp && resetn;
    assign ram_we     = cur_write && !cur_err;
    assign ram_addr   = cur_addr[AW+1:2];

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .be_i    (cur_be),
        .addr_i  (ram_addr),
        .wdata_i (cur_wdata),
        .rdata_o (ram_rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept, count down in WAIT, single RESP cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; response data is forced to zero off-pulse.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        stall     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
            end
            ST_WAIT: stall = 1'b1;
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = err_q ? 32'd0 : ram_rdata;
            end
            default: ;
        endcase
    end

    // Request capture on accept and latency countdown while waiting.
    always_comb begin
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        if (accept) begin
            cnt_d   = CNT_LOAD;
            write_d = req_write;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            be_d    = req_be;
            err_d   = cur_err;
        end else if (state_q == ST_WAIT) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Request registers; reset drops any pending request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
        end
    end

endmodule
